// File: rtl/fifo_pkg.sv
// Shared constants for the 16-deep, 4-bit synchronous FIFO and its consumers.
//   NIBBLE_W   : FIFO data width
//   FIFO_DEPTH : FIFO entry count
//   cnt_w()    : width of a counter that must hold 0..n inclusive
package fifo_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int FIFO_DEPTH = 16;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Output holding register for the nibble packer: one word on a valid/ready
// stream. A load is only requested when the register is free, so a held
// word is never overwritten.
//   clk, rst           : clock, synchronous active-high reset
//   load/load_data/cnt : new word to present from the next cycle
//   out_ready          : downstream accept
//   out_data/cnt/valid : presented word
//   out_free           : register can take a load on this edge
module pack_out_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [3:0]    load_cnt,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [3:0]    out_cnt,
    output logic          out_valid,
    output logic          out_free
);

    logic [DW-1:0] data_q, data_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d;

    assign out_free  = !valid_q || out_ready;
    assign out_data  = data_q;
    assign out_cnt   = cnt_q;
    assign out_valid = valid_q;

    always_comb begin
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load) begin
            // Also covers a transfer and a new load on the same edge.
            data_d  = load_data;
            cnt_d   = load_cnt;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/fifo_nibble_packer.sv
// Read-side consumer of the 4-bit FIFO: pops nibbles while the FIFO is
// non-empty and packs NIBBLES of them (first nibble in the LSBs) into one
// word presented on a valid/ready stream.
//   clk, rst            : clock, synchronous active-high reset
//   fifo_empty          : FIFO empty flag
//   fifo_data           : FIFO read data, valid the cycle after a pop
//   rd_en               : pop request (pop on the same edge)
//   out_data/out_cnt    : packed word and its valid nibble count
//   out_valid/out_ready : output handshake
// Optional macro PACKER_FLUSH_EN: emit a partial word after FLUSH_CYCLES
// idle cycles with an empty FIFO.
module fifo_nibble_packer
    import fifo_pkg::*;
#(
    parameter int NIBBLES      = 2,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifo_empty,
    input  logic [NIBBLE_W-1:0]         fifo_data,
    output logic                        rd_en,
    output logic [NIBBLE_W*NIBBLES-1:0] out_data,
    output logic [3:0]                  out_cnt,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int          DW      = NIBBLE_W * NIBBLES;
    localparam int          CW      = cnt_w(NIBBLES);
    localparam logic [CW:0] NIB_EXT = (CW+1)'(NIBBLES);

    if (NIBBLES < 2 || NIBBLES > 8 || FLUSH_CYCLES < 1) begin : g_bad_cfg
        $error("fifo_nibble_packer: NIBBLES must be 2..8 and FLUSH_CYCLES >= 1");
    end

    logic [DW-1:0] acc_q, acc_d, acc_wr;
    logic [CW-1:0] cap_cnt_q, cap_cnt_d;
    logic          inflight_q, inflight_d;
    logic          cap_last, cap_full;
    logic          out_free, load, flush_fire;
    logic [DW-1:0] load_data;
    logic [3:0]    load_cnt;

    assign cap_last = (cap_cnt_q == CW'(NIBBLES - 1));
    assign cap_full = (cap_cnt_q == CW'(NIBBLES));

    // Count the in-flight nibble so we never pop more than one word's worth.
    assign rd_en = !rst && !fifo_empty &&
                   (({1'b0, cap_cnt_q} + {{CW{1'b0}}, inflight_q}) < NIB_EXT);

`ifdef PACKER_FLUSH_EN
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          flush_idle;

    assign flush_idle = (cap_cnt_q != '0) && !cap_full && !inflight_q &&
                        fifo_empty && out_free;
    assign flush_fire = flush_idle && (flush_cnt_q == FW'(FLUSH_CYCLES));

    always_comb begin
        flush_cnt_d = '0;
        if (flush_idle && !flush_fire) flush_cnt_d = flush_cnt_q + FW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) flush_cnt_q <= '0;
        else     flush_cnt_q <= flush_cnt_d;
    end
`else
    assign flush_fire = 1'b0;
`endif

    always_comb begin
        // Accumulator with the arriving nibble dropped into slot cap_cnt.
        acc_wr = acc_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (cap_cnt_q == CW'(i)) acc_wr[i*NIBBLE_W +: NIBBLE_W] = fifo_data;
        end

        acc_d      = acc_q;
        cap_cnt_d  = cap_cnt_q;
        inflight_d = rd_en;
        load       = 1'b0;
        load_data  = acc_wr;
        load_cnt   = 4'(NIBBLES);

        if (inflight_q) begin
            if (cap_last && out_free) begin
                // Completed word bypasses the accumulator straight to the output.
                load      = 1'b1;
                acc_d     = '0;
                cap_cnt_d = '0;
            end else begin
                // cap_cnt may reach NIBBLES here: full word parked, reads stop.
                acc_d     = acc_wr;
                cap_cnt_d = cap_cnt_q + CW'(1);
            end
        end else if (cap_full && out_free) begin
            load      = 1'b1;
            load_data = acc_q;
            acc_d     = '0;
            cap_cnt_d = '0;
        end else if (flush_fire) begin
            // Unfilled slots are already zero: acc is cleared on every emit.
            load      = 1'b1;
            load_data = acc_q;
            load_cnt  = 4'(cap_cnt_q);
            acc_d     = '0;
            cap_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cap_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cap_cnt_q  <= cap_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    pack_out_reg #(
        .DW(DW)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_data(load_data),
        .load_cnt (load_cnt),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_cnt  (out_cnt),
        .out_valid(out_valid),
        .out_free (out_free)
    );

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer (NIBBLES=2): a queue-based FIFO model feeds
// the DUT; a scoreboard groups popped nibbles into expected words.
module tb_fifo_nibble_packer;

    localparam int N  = 2;
    localparam int FC = 8;
    localparam int DW = 4 * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [3:0]    fifo_data = 4'h0;
    logic          rd_en;
    logic [DW-1:0] out_data;
    logic [3:0]    out_cnt;
    logic          out_valid;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    fifo_nibble_packer #(
        .NIBBLES     (N),
        .FLUSH_CYCLES(FC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .rd_en     (rd_en),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- FIFO model ----------------
    logic       push_en = 1'b0;
    logic [3:0] push_val = 4'h0;
    logic       flush_fifo = 1'b0;
    logic [3:0] fq[$];
    logic [3:0] popped[$];    // every nibble popped since last reset, in order
    int         pops_total = 0;

    always @(posedge clk) begin : fifo_model
        logic [3:0] v;
        if (rst) popped.delete();
        if (flush_fifo) fq.delete();
        if (rd_en && fq.size() > 0) begin
            v = fq.pop_front();
            fifo_data <= v;
            popped.push_back(v);
            pops_total++;
        end
        if (push_en) fq.push_back(push_val);
        fifo_empty <= (fq.size() == 0);
    end

    // ---------------- checking ----------------
    int            n_chk = 0;
    int            n_fail = 0;
    int            sb_idx = 0;
    logic [DW-1:0] got_q[$];
    bit            held = 1'b0;
    logic [DW-1:0] held_data;
    logic [3:0]    held_cnt;
    int            pops_base, got_base;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] got(input int i);
        return (got_q.size() > got_base + i) ? got_q[got_base + i] : 'x;
    endfunction

    task automatic monitor();
        logic [DW-1:0] exp;
        if (rst) begin
            sb_idx = 0;
            held   = 1'b0;
        end else begin
            chk("rd_en_while_empty", 32'(rd_en && fifo_empty), 0);
            if (held) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", 32'(out_data), 32'(held_data));
                chk("hold_cnt", 32'(out_cnt), 32'(held_cnt));
            end
            chk("occupancy", 32'((popped.size() - sb_idx) <= (N + (out_valid ? N : 0))), 1);
            if (out_valid && out_ready) begin
                exp = '0;
                for (int i = 0; i < N; i++)
                    if (i < int'(out_cnt) && sb_idx + i < popped.size())
                        exp[i*4 +: 4] = popped[sb_idx + i];
`ifdef PACKER_FLUSH_EN
                chk("word_cnt_range", 32'(out_cnt >= 1 && out_cnt <= N), 1);
`else
                chk("word_cnt", 32'(out_cnt), N);
`endif
                chk("sb_avail", 32'((popped.size() - sb_idx) >= int'(out_cnt)), 1);
                chk("word_data", 32'(out_data), 32'(exp));
                sb_idx += int'(out_cnt);
                got_q.push_back(out_data);
            end
            held      = out_valid && !out_ready;
            held_data = out_data;
            held_cnt  = out_cnt;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push1(input logic [3:0] v);
        push_en  = 1'b1;
        push_val = v;
        tick();
        push_en  = 1'b0;
    endtask

    // Reset, empty the FIFO, preload n nibbles while still in reset.
    task automatic do_reset(input logic [3:0] nibs[8], input int n);
        rst        = 1'b1;
        flush_fifo = 1'b1;
        tick();
        flush_fifo = 1'b0;
        for (int i = 0; i < n; i++) push1(nibs[i]);
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_cnt", 32'(out_cnt), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        rst       = 1'b0;
        pops_base = pops_total;
        got_base  = got_q.size();
    endtask

    typedef struct {
        logic [3:0]    nib[4];
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
    } vec_t;

    initial begin
        vec_t       tbl[4];
        logic [3:0] lcl[8];
        int         first_rd, first_v;
        logic [DW-1:0] v_data;
        logic [3:0]    v_cnt;

        tbl[0].nib = '{4'h1, 4'h2, 4'h3, 4'h4}; tbl[0].w0 = 8'h21; tbl[0].w1 = 8'h43;
        tbl[1].nib = '{4'hF, 4'h0, 4'h0, 4'hF}; tbl[1].w0 = 8'h0F; tbl[1].w1 = 8'hF0;
        tbl[2].nib = '{4'hA, 4'hB, 4'hC, 4'hD}; tbl[2].w0 = 8'hBA; tbl[2].w1 = 8'hDC;
        tbl[3].nib = '{4'h0, 4'h0, 4'h9, 4'h6}; tbl[3].w0 = 8'h00; tbl[3].w1 = 8'h69;
        lcl = '{default: 4'h0};

        // Reset then idle with an empty FIFO.
        do_reset(lcl, 0);
        for (int c = 0; c < 20; c++) begin
            chk("idle_rd_en", 32'(rd_en), 0);
            chk("idle_valid", 32'(out_valid), 0);
            chk("idle_data", 32'(out_data), 0);
            tick();
        end

        // Table: four nibbles in, two words out, 3-cycle first-word latency.
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) lcl[i] = tbl[t].nib[i];
            do_reset(lcl, 4);
            out_ready = 1'b1;
            first_rd  = -1;
            first_v   = -1;
            for (int c = 0; c < 30; c++) begin
                #1;
                if (rd_en && first_rd < 0) first_rd = c;
                if (out_valid && first_v < 0) first_v = c;
                tick();
            end
            chk("tbl_latency", 32'(first_v - first_rd), 3);
            chk("tbl_pops", 32'(pops_total - pops_base), 4);
            chk("tbl_words", 32'(got_q.size() - got_base), 2);
            chk("tbl_w0", 32'(got(0)), 32'(tbl[t].w0));
            chk("tbl_w1", 32'(got(1)), 32'(tbl[t].w1));
        end

        // Backpressure: six nibbles, downstream stalled.
        for (int i = 0; i < 6; i++) lcl[i] = 4'(i + 1);
        do_reset(lcl, 6);
        out_ready = 1'b0;
        ticks(15);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_data", 32'(out_data), 32'h21);
        chk("bp_pops", 32'(pops_total - pops_base), 4);
        chk("bp_rd_en", 32'(rd_en), 0);
        out_ready = 1'b1;
        ticks(20);
        chk("bp_words", 32'(got_q.size() - got_base), 3);
        chk("bp_w0", 32'(got(0)), 32'h21);
        chk("bp_w1", 32'(got(1)), 32'h43);
        chk("bp_w2", 32'(got(2)), 32'h65);

`ifndef PACKER_FLUSH_EN
        // FIFO runs empty mid-word: the partial word waits indefinitely.
        lcl[0] = 4'h5;
        do_reset(lcl, 1);
        out_ready = 1'b1;
        ticks(15);
        chk("mid_no_word", 32'(got_q.size() - got_base), 0);
        chk("mid_valid", 32'(out_valid), 0);
        push1(4'hA);
        ticks(10);
        chk("mid_words", 32'(got_q.size() - got_base), 1);
        chk("mid_w0", 32'(got(0)), 32'hA5);
`endif

        // Reset while a nibble is in flight.
        for (int i = 0; i < 4; i++) lcl[i] = 4'(i + 1);
        do_reset(lcl, 4);
        out_ready = 1'b1;
        #1;
        chk("ro_rd_en", 32'(rd_en), 1);
        tick();
        rst = 1'b1;
        #1;
        chk("ro_rd_en_rst", 32'(rd_en), 0);
        flush_fifo = 1'b1;
        tick();
        flush_fifo = 1'b0;
        chk("ro_valid", 32'(out_valid), 0);
        chk("ro_data", 32'(out_data), 0);
        chk("ro_cnt", 32'(out_cnt), 0);
        rst      = 1'b0;
        got_base = got_q.size();
        push1(4'h9); push1(4'h8); push1(4'h7); push1(4'h6);
        ticks(20);
        chk("ro_words", 32'(got_q.size() - got_base), 2);
        chk("ro_w0", 32'(got(0)), 32'h89);
        chk("ro_w1", 32'(got(1)), 32'h67);

`ifdef PACKER_FLUSH_EN
        // Lone nibble flushed after the idle timeout.
        lcl[0] = 4'h7;
        do_reset(lcl, 1);
        out_ready = 1'b1;
        first_rd  = -1;
        first_v   = -1;
        v_data    = '0;
        v_cnt     = '0;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (rd_en && first_rd < 0) first_rd = c;
            if (out_valid && first_v < 0) begin
                first_v = c;
                v_data  = out_data;
                v_cnt   = out_cnt;
            end
            tick();
        end
        // Capture lands two edges after the rd_en cycle, word 9 edges later.
        chk("fl_latency", 32'(first_v - first_rd), 11);
        chk("fl_data", 32'(v_data), 32'h07);
        chk("fl_cnt", 32'(v_cnt), 1);
`endif

        // Random traffic against the scoreboard.
        do_reset(lcl, 0);
        for (int c = 0; c < 800; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            push_en   = (fq.size() < 14) && ($urandom_range(0, 1) == 1);
            push_val  = 4'($urandom_range(0, 15));
            tick();
        end
        push_en   = 1'b0;
        out_ready = 1'b1;
        ticks(40);
        chk("rnd_drained", 32'(fq.size()), 0);
`ifdef PACKER_FLUSH_EN
        chk("rnd_leftover", 32'(popped.size() - sb_idx), 0);
`else
        chk("rnd_leftover", 32'((popped.size() - sb_idx) < N), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
